// File: rtl/freq_tick_scheduler.sv
// freq_tick_scheduler: programmable Tick/Phase period generator shared by two round-robin requesters.
// A granted limit waits in PEND and is applied only at a wrap, so no period is ever truncated.
module freq_tick_scheduler #(
   parameter int MasterFrequency  = 100000000,
   parameter int DefaultFrequency = 100,
   parameter int bitsNumber       = 20
) (
   input  logic                  InputCLK,
   input  logic                  Reset,
   input  logic                  Req0,
   input  logic [bitsNumber-1:0] Limit0,
   output logic                  Ack0,
   input  logic                  Req1,
   input  logic [bitsNumber-1:0] Limit1,
   output logic                  Ack1,
   output logic                  Tick,
   output logic                  Phase,
   output logic [bitsNumber-1:0] ActiveLimit,
   output logic                  Owner,
   output logic                  Busy
);
   localparam logic [bitsNumber-1:0] DefaultLimit = bitsNumber'(MasterFrequency / DefaultFrequency);
   typedef enum logic [1:0] {IDLE, PEND, ACK} stateT;
   stateT state;
   logic [bitsNumber-1:0] counter, pendLimit, grantLimit, clampedLimit;
   logic pendOwner, lastGrant, grantSel, wrap;
   always_comb begin
      wrap = counter == ActiveLimit - bitsNumber'(1);
      grantSel = (Req0 & Req1) ? ~lastGrant : Req1;
      grantLimit = grantSel ? Limit1 : Limit0;
      clampedLimit = grantLimit < bitsNumber'(2) ? bitsNumber'(2) : grantLimit;
      Tick = wrap;
      Phase = counter >= (ActiveLimit >> 1);
      Busy = state != IDLE;
   end
   always_ff @(posedge InputCLK) begin
      if (Reset) begin
         counter <= '0;
         ActiveLimit <= DefaultLimit;
         state <= IDLE;
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
         Owner <= 1'b0;
         lastGrant <= 1'b1;
         pendLimit <= DefaultLimit;
         pendOwner <= 1'b0;
      end else begin
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
         counter <= wrap ? '0 : counter + bitsNumber'(1);
         case (state)
            IDLE: if (Req0 | Req1) begin
               pendLimit <= clampedLimit;
               pendOwner <= grantSel;
               state <= PEND;
            end
            PEND: if (wrap) begin
               ActiveLimit <= pendLimit;
               Ack0 <= ~pendOwner;
               Ack1 <= pendOwner;
               Owner <= pendOwner;
               lastGrant <= pendOwner;
               state <= ACK;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_freq_tick_scheduler.sv
// tb_freq_tick_scheduler: directed checks of period, arbitration, clamp, odd split and reset abort.
module tb_freq_tick_scheduler;
   logic InputCLK = 1'b0;
   logic Reset = 1'b1, Req0 = 1'b0, Req1 = 1'b0;
   logic [7:0] Limit0 = '0, Limit1 = '0, ActiveLimit;
   logic Ack0, Ack1, Tick, Phase, Owner, Busy;
   int compared = 0, mismatched = 0, n;

   freq_tick_scheduler #(.MasterFrequency(100), .DefaultFrequency(10), .bitsNumber(8)) dut (
      .InputCLK(InputCLK), .Reset(Reset), .Req0(Req0), .Limit0(Limit0), .Ack0(Ack0),
      .Req1(Req1), .Limit1(Limit1), .Ack1(Ack1), .Tick(Tick), .Phase(Phase),
      .ActiveLimit(ActiveLimit), .Owner(Owner), .Busy(Busy));

   always #5 InputCLK = ~InputCLK;

   task automatic step();
      @(posedge InputCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitAck(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!(Ack0 | Ack1) && cnt < 40);
   endtask

   task automatic checkPeriod(input int lim, input int samples);
      for (int i = 0; i < samples; i++) begin
         check($sformatf("tick L%0d s%0d", lim, i), Tick, (i % lim) == lim - 1);
         check($sformatf("phase L%0d s%0d", lim, i), Phase, (i % lim) >= lim / 2);
         step();
      end
   endtask

   initial begin
      step();
      step();
      check("rst tick", Tick, 0);
      check("rst phase", Phase, 0);
      check("rst limit", ActiveLimit, 10);
      check("rst ack", {Ack0, Ack1}, 0);
      check("rst busy", Busy, 0);
      check("rst owner", Owner, 0);
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("def tick c%0d", i), Tick, i == 9);
         check($sformatf("def phase c%0d", i), Phase, i >= 5);
         check($sformatf("def ack c%0d", i), {Ack0, Ack1}, 0);
         step();
      end
      step(); step(); step();
      Req0 = 1'b1; Limit0 = 8'd4;
      step();
      check("pend busy", Busy, 1);
      waitAck(n);
      check("ack latency L4", n + 1, 7);
      check("ack0 L4", {Ack0, Ack1}, 2'b10);
      check("limit 4", ActiveLimit, 4);
      check("owner 0", Owner, 0);
      check("busy in ack", Busy, 1);
      Req0 = 1'b0;
      checkPeriod(4, 8);

      Reset = 1'b1;
      step();
      Reset = 1'b0;
      Req0 = 1'b1; Limit0 = 8'd6; Req1 = 1'b1; Limit1 = 8'd8;
      waitAck(n);
      check("tie1 latency", n, 10);
      check("tie1 ack", {Ack0, Ack1}, 2'b10);
      check("tie1 limit", ActiveLimit, 6);
      Req0 = 1'b0;
      waitAck(n);
      check("tie2 latency", n, 6);
      check("tie2 ack", {Ack0, Ack1}, 2'b01);
      check("tie2 limit", ActiveLimit, 8);
      check("tie2 owner", Owner, 1);
      Req0 = 1'b1; Limit0 = 8'd1; Limit1 = 8'd3;
      waitAck(n);
      check("tie3 latency", n, 8);
      check("tie3 ack", {Ack0, Ack1}, 2'b10);
      check("clamp limit", ActiveLimit, 2);
      check("tie3 owner", Owner, 0);
      Req0 = 1'b0; Req1 = 1'b0;
      checkPeriod(2, 6);

      Req0 = 1'b1; Limit0 = 8'd7;
      step();
      Limit0 = 8'd50;
      waitAck(n);
      check("odd ack", {Ack0, Ack1}, 2'b10);
      check("odd limit captured", ActiveLimit, 7);
      Req0 = 1'b0;
      checkPeriod(7, 14);

      Req0 = 1'b1; Limit0 = 8'd3;
      step();
      check("abort busy", Busy, 1);
      Reset = 1'b1;
      step();
      check("abort ack", {Ack0, Ack1}, 0);
      check("abort limit", ActiveLimit, 10);
      check("abort busy clr", Busy, 0);
      check("abort tick", Tick, 0);
      Reset = 1'b0;
      waitAck(n);
      check("regrant latency", n, 10);
      check("regrant ack", {Ack0, Ack1}, 2'b10);
      check("regrant limit", ActiveLimit, 3);
      Req0 = 1'b0;
      step();
      check("ack one cycle", {Ack0, Ack1}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
